// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: START / repeated START / STOP, ACK/NACK, open-drain pads.
// Define I2C_CLK_STRETCH_EN to add scl_i and honour slave clock stretching.
module i2c_byte_master #(
  parameter int CLK_DIV = 250,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
`ifdef I2C_CLK_STRETCH_EN
  input  logic       scl_i,
`endif
  input  logic       sda_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RSTART, S_BIT,
    S_ACKB, S_HOLD, S_STOP
  } state_e;

  localparam logic [DIV_W-1:0] LAST =
    DIV_W'(CLK_DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ph_q, ph_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rw_q, rw_d;
  logic             stop_q, stop_d;
  logic             ack_q, ack_d;
  logic             nack_q, nack_d;
  logic             valid_q, valid_d;
  logic             run, last, stall;
  logic             adv, accept, lowp;

  assign cmd_ready = (state_q == S_IDLE) ||
                     (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_nack  = nack_q;
  assign accept    = cmd_valid && cmd_ready;
  assign run       = !cmd_ready;
  assign last      = (cnt_q == LAST);
  assign lowp      = (ph_q == 2'd0) || (ph_q == 2'd3);

  always_comb begin
    stall = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    // Slave may hold SCL low right after we release it.
    stall = (ph_q == 2'd1) && (cnt_q == '0) && !scl_i &&
            (state_q inside {S_RSTART, S_BIT, S_ACKB, S_STOP});
`endif
    adv = run && last && !stall;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    stop_d  = stop_q;
    ack_d   = ack_q;
    nack_d  = nack_q;
    valid_d = 1'b0;
    scl_oe  = 1'b0;
    sda_oe  = 1'b0;
    if (run && !stall)
      cnt_d = last ? '0 : cnt_q + DIV_W'(1);
    if (adv)
      ph_d = ph_q + 2'd1;
    if (accept) begin
      cnt_d  = '0;
      ph_d   = 2'd0;
      bit_d  = 3'd7;
      tx_d   = cmd_wdata;
      rw_d   = cmd_rw;
      stop_d = cmd_stop;
    end
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_START;
      end
      S_HOLD: begin
        scl_oe = 1'b1;
        sda_oe = 1'b1;
        if (accept)
          state_d = cmd_start ? S_RSTART : S_BIT;
      end
      S_START: begin
        scl_oe = (ph_q == 2'd2);
        sda_oe = (ph_q != 2'd0);
        if (adv && ph_q == 2'd2) begin
          state_d = S_BIT;
          ph_d    = 2'd0;
        end
      end
      S_RSTART: begin
        scl_oe = lowp;
        sda_oe = ph_q[1];
        if (adv && ph_q == 2'd3) state_d = S_BIT;
      end
      S_BIT: begin
        scl_oe = lowp;
        sda_oe = !rw_q && !tx_q[bit_q];
        if (adv && ph_q == 2'd2)
          rx_d = {rx_q[6:0], sda_i};
        if (adv && ph_q == 2'd3) begin
          if (bit_q == 3'd0) state_d = S_ACKB;
          else bit_d = bit_q - 3'd1;
        end
      end
      S_ACKB: begin
        scl_oe = lowp;
        sda_oe = rw_q && !stop_q;
        if (adv && ph_q == 2'd2) ack_d = sda_i;
        if (adv && ph_q == 2'd3) begin
          valid_d = 1'b1;
          rdata_d = rw_q ? rx_q : 8'h00;
          nack_d  = !rw_q && ack_q;
          state_d = stop_q ? S_STOP : S_HOLD;
        end
      end
      S_STOP: begin
        scl_oe = (ph_q == 2'd0);
        sda_oe = (ph_q != 2'd2);
        if (adv && ph_q == 2'd2) begin
          state_d = S_IDLE;
          ph_d    = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ph_q    <= 2'd0;
      bit_q   <= 3'd7;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      rdata_q <= 8'h00;
      rw_q    <= 1'b0;
      stop_q  <= 1'b0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      stop_q  <= stop_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with a bus-level slave and monitor.
// Stretch sequence runs only when I2C_CLK_STRETCH_EN is defined.
module tb_i2c_byte_master;
  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_start = 1'b0;
  logic       cmd_stop = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ready, rsp_valid, rsp_nack, busy;
  logic       scl_oe, sda_oe, sda_i;
  logic [7:0] rsp_rdata;
  logic       stretch_low = 1'b0;
  logic       scl_line, sda_line, slv_low;
  int         total = 0;
  int         bad = 0;
  int         lat;

  always #5 clk = ~clk;

  i2c_byte_master #(.CLK_DIV(CD), .DIV_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_start(cmd_start),
    .cmd_stop(cmd_stop),
    .cmd_rw(cmd_rw),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack),
    .busy(busy),
    .scl_oe(scl_oe),
    .sda_oe(sda_oe),
`ifdef I2C_CLK_STRETCH_EN
    .scl_i(scl_line),
`endif
    .sda_i(sda_i)
  );

  assign scl_line = ~scl_oe & ~stretch_low;
  assign sda_line = ~sda_oe & ~slv_low;
  assign sda_i    = sda_line;

  // Slave: slot 0..7 data bits, slot 8 acknowledge.
  int         slot = -1;
  int         n_start = 0;
  int         n_stop = 0;
  logic       rd_mode = 1'b0;
  logic       slv_ack = 1'b0;
  logic       mnack = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  logic [7:0] mon_byte = 8'h00;
  logic       mon_ack = 1'b0;
  logic       scl_p = 1'b1;
  logic       sda_p = 1'b1;

  always_comb begin
    slv_low = 1'b0;
    if (slot >= 0 && slot < 8)
      slv_low = rd_mode & ~mnack & ~rd_byte[3'(7 - slot)];
    else if (slot == 8)
      slv_low = ~rd_mode & slv_ack;
  end

  always @(negedge clk) begin
    scl_p <= scl_line;
    sda_p <= sda_line;
    if (scl_p && scl_line && sda_p && !sda_line) begin
      slot    <= -1;
      mnack   <= 1'b0;
      n_start <= n_start + 1;
    end else if (scl_p && scl_line && !sda_p && sda_line) begin
      slot   <= -1;
      n_stop <= n_stop + 1;
    end else if (scl_p && !scl_line) begin
      slot <= (slot == 8) ? 0 : slot + 1;
    end else if (!scl_p && scl_line) begin
      if (slot >= 0 && slot < 8)
        mon_byte <= {mon_byte[6:0], sda_line};
      else if (slot == 8) begin
        mon_ack <= sda_line;
        if (rd_mode) mnack <= sda_line;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       start;
    logic       stop;
    logic       rw;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] rbyte;
    int         lat;
    logic [7:0] rdata;
    logic       nack;
    logic [7:0] mon;
    logic       mack;
    int         starts;
  } vec_t;

  vec_t v[5];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    v[0] = '{1'b1, 1'b1, 1'b0, 8'hA4, 1'b1, 8'h00,
             156, 8'h00, 1'b0, 8'hA4, 1'b0, 1};
    v[1] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h00,
             156, 8'h00, 1'b1, 8'h3C, 1'b1, 1};
    v[2] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h5C,
             144, 8'h5C, 1'b0, 8'h5C, 1'b1, 0};
    v[3] = '{1'b1, 1'b0, 1'b0, 8'h50, 1'b1, 8'h00,
             156, 8'h00, 1'b0, 8'h50, 1'b0, 1};
    v[4] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h00,
             160, 8'h00, 1'b0, 8'hA5, 1'b0, 1};

    repeat (3) @(negedge clk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_nack", rsp_nack, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      int   s0, p0;
      logic ackb_ok;
      @(negedge clk);
      chk("ready_pre", cmd_ready, 1);
      rd_mode   = v[i].rw;
      slv_ack   = v[i].ack;
      rd_byte   = v[i].rbyte;
      cmd_start = v[i].start;
      cmd_stop  = v[i].stop;
      cmd_rw    = v[i].rw;
      cmd_wdata = v[i].wdata;
      cmd_valid = 1'b1;
      s0 = n_start;
      p0 = n_stop;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      lat = -1;
      ackb_ok = 1'b1;
      for (int k = 0; k < 400 && lat < 0; k++) begin
        @(negedge clk);
        if (k == 0) chk("ready_drop", cmd_ready, 0);
        if (k >= v[i].lat - 16 && k < v[i].lat &&
            sda_oe !== (v[i].rw & ~v[i].stop))
          ackb_ok = 1'b0;
        if (rsp_valid) lat = k;
      end
      chk("latency", lat, v[i].lat);
      chk("rdata", rsp_rdata, v[i].rdata);
      chk("nack", rsp_nack, v[i].nack);
      chk("bus_byte", mon_byte, v[i].mon);
      chk("bus_ack", mon_ack, v[i].mack);
      chk("ackb_sda", ackb_ok, 1);
      chk("starts", n_start - s0, v[i].starts);
      chk("stops_pre", n_stop - p0, 0);
      @(negedge clk);
      chk("pulse_end", rsp_valid, 0);
      chk("rdata_held", rsp_rdata, v[i].rdata);
      if (v[i].stop) begin
        repeat (10) @(negedge clk);
        chk("stop_busy", busy, 1);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_scl", scl_oe, 0);
        chk("idle_sda", sda_oe, 0);
        @(negedge clk);
        chk("stops", n_stop - p0, 1);
      end else begin
        chk("hold_scl", scl_oe, 1);
        chk("hold_sda", sda_oe, 1);
        chk("hold_ready", cmd_ready, 1);
        chk("hold_busy", busy, 1);
      end
    end

    // Asynchronous reset in the middle of a write byte.
    @(negedge clk);
    rd_mode   = 1'b0;
    slv_ack   = 1'b1;
    cmd_start = 1'b1;
    cmd_stop  = 1'b1;
    cmd_rw    = 1'b0;
    cmd_wdata = 8'h00;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (62) @(negedge clk);
    chk("mid_scl", scl_oe, 1);
    chk("mid_sda", sda_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_scl", scl_oe, 0);
    chk("arst_sda", sda_oe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_ready", cmd_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_valid", rsp_valid, 0);

`ifdef I2C_CLK_STRETCH_EN
    @(negedge clk);
    cmd_wdata = 8'hA4;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 400 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 80) stretch_low = 1'b1;
      if (k == 100) stretch_low = 1'b0;
      if (rsp_valid) lat = k;
    end
    chk("stretch_lat", lat, 176);
    chk("stretch_byte", mon_byte, 8'hA4);
    repeat (14) @(negedge clk);
    chk("stretch_idle", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
